// File: rtl/cond_issue_ctrl.sv
// Issue-stage conditional-execution controller: owns NZCV, stalls on in-flight flag setters, squashes after taken branches.
// Optional COND_FLAG_FWD_EN: evaluate a stalled condition against returning ALU flags in the same cycle.
module cond_issue_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_PEND     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_cond,
  input  logic       in_s,
  input  logic       in_branch,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_exec,
  output logic       out_taken,
  input  logic       alu_flags_valid,
  input  logic [3:0] alu_flags,
  output logic [3:0] sr,
  output logic [2:0] pend_cnt,
  output logic       flush
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  localparam logic [3:0] COND_AL    = 4'd14;
  localparam logic [2:0] MAX_PEND_L = 3'(MAX_PEND);
  localparam logic [3:0] FLUSH_L    = 4'(FLUSH_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic [3:0] sr_q, sr_d;
  logic [2:0] pend_q, pend_d;
  logic       out_valid_q, out_valid_d;
  logic       out_exec_q, out_exec_d;
  logic       out_taken_q, out_taken_d;

  logic       fwd, stall, pass, accept, issue, flags_ret, set_flags;
  logic [3:0] eval_flags;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c && !z;
      4'd9:    r = !c || z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z && (n == v);
      4'd13:   r = z || (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    fwd = 1'b0;
`ifdef COND_FLAG_FWD_EN
    // Last pending setter's flags arrive now: use them directly instead of waiting for sr.
    fwd = alu_flags_valid && (pend_q == 3'd1) && (in_cond != COND_AL);
`endif
    stall      = ((pend_q != 3'd0) && (in_cond != COND_AL) && !fwd) ||
                 ((pend_q == MAX_PEND_L) && in_s);
    eval_flags = fwd ? alu_flags : sr_q;
    pass       = cond_pass(in_cond, eval_flags);
    in_ready   = (state_q == ST_FLUSH) || ((!out_valid_q || out_ready) && !stall);
    accept     = in_valid && in_ready;
    issue      = accept && (state_q == ST_RUN);
    flags_ret  = alu_flags_valid && (pend_q != 3'd0);
    set_flags  = issue && in_s && pass;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    sr_d        = sr_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_exec_d  = out_exec_q;
    out_taken_d = out_taken_q;

    // Output register drains normally even while squashing new arrivals.
    if (issue) begin
      out_valid_d = 1'b1;
      out_exec_d  = pass;
      out_taken_d = pass && in_branch;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_exec_d  = 1'b0;
      out_taken_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (issue && pass && in_branch) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_L;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q <= 4'd1) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    case ({set_flags, flags_ret})
      2'b10:   pend_d = pend_q + 3'd1;
      2'b01:   pend_d = pend_q - 3'd1;
      default: pend_d = pend_q;
    endcase

    if (flags_ret) sr_d = alu_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      sr_q        <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_exec_q  <= 1'b0;
      out_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      sr_q        <= sr_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_exec_q  <= out_exec_d;
      out_taken_q <= out_taken_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_exec  = out_exec_q;
  assign out_taken = out_taken_q;
  assign sr        = sr_q;
  assign pend_cnt  = pend_q;
  assign flush     = (state_q == ST_FLUSH);

endmodule
